// File: rtl/even_odd_pkg.sv
// rtl/even_odd_pkg.sv - shared state encoding and default widths for the even/odd arbiter
package even_odd_pkg;

  localparam int DEF_W     = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/even_or_odd.sv
// rtl/even_or_odd.sv - combinational parity classifier, odd=1 when the operand is odd
module even_or_odd #(
  parameter int W = 4
) (
  input  logic [W-1:0] num,
  output logic         odd
);

  localparam logic [W-1:0] LSB_MASK = W'(1);

  assign odd = |(num & LSB_MASK);

endmodule

// File: rtl/even_odd_arbiter.sv
// rtl/even_odd_arbiter.sv - two-requester round-robin arbiter feeding a shared parity classifier
module even_odd_arbiter
  import even_odd_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [W-1:0]     req_num0,
  input  logic [W-1:0]     req_num1,
  output logic [1:0]       req_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [W-1:0]     res_num,
  output logic             res_odd,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] even_cnt,
  output logic [CNT_W-1:0] odd_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t         state;
  logic           last_grant;
  logic           grant_id;
  logic [W-1:0]   grant_num;
  logic           grant_odd;
  logic           xfer;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    req_ready = 2'b00;
    if (!rst && state == IDLE) begin
      case (req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
        2'b11:   req_ready = last_grant ? 2'b01 : 2'b10;
        default: req_ready = 2'b00;
      endcase
    end
  end

  assign grant_id  = req_ready[1];
  assign grant_num = grant_id ? req_num1 : req_num0;
  assign xfer      = |req_ready;

  even_or_odd #(.W(W)) u_classifier (
    .num (grant_num),
    .odd (grant_odd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      res_valid  <= 1'b0;
      res_id     <= 1'b0;
      res_num    <= '0;
      res_odd    <= 1'b0;
      last_grant <= 1'b1;
      even_cnt   <= '0;
      odd_cnt    <= '0;
    end else begin
      if (state == IDLE) begin
        if (xfer) begin
          state      <= BUSY;
          res_valid  <= 1'b1;
          res_id     <= grant_id;
          res_num    <= grant_num;
          res_odd    <= grant_odd;
          last_grant <= grant_id;
        end
      end else if (res_ready) begin
        state     <= IDLE;
        res_valid <= 1'b0;
      end

      // Counters track accepted operands; clear wins over a same-edge increment.
      if (cnt_clr) begin
        even_cnt <= '0;
        odd_cnt  <= '0;
      end else if (xfer) begin
        if (grant_odd) begin
          if (odd_cnt != CNT_MAX) odd_cnt <= odd_cnt + 1'b1;
        end else begin
          if (even_cnt != CNT_MAX) even_cnt <= even_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_even_odd_arbiter.sv
// tb/tb_even_odd_arbiter.sv - randomized and directed self-checking bench for even_odd_arbiter
module tb_even_odd_arbiter;

  localparam int W     = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req_valid = 2'b00;
  logic [W-1:0]     req_num0 = '0;
  logic [W-1:0]     req_num1 = '0;
  logic [1:0]       req_ready;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic             res_id;
  logic [W-1:0]     res_num;
  logic             res_odd;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] even_cnt;
  logic [CNT_W-1:0] odd_cnt;

  int tests  = 0;
  int failed = 0;

  // Reference state, kept as plain integers.
  int m_busy = 0, m_id = 0, m_num = 0, m_odd = 0, m_last = 1;
  int m_even = 0, m_oddc = 0;
  int exp_ready = 0;

  int pend_v[2];
  int pend_n[2];

  always #5 clk = ~clk;

  even_odd_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_num0  (req_num0),
    .req_num1  (req_num1),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_num   (res_num),
    .res_odd   (res_odd),
    .cnt_clr   (cnt_clr),
    .even_cnt  (even_cnt),
    .odd_cnt   (odd_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare DUT against the model, advance the model.
  task automatic step(input int v, input int n0, input int n1, input int rr,
                      input int clr, input int r);
    int g;
    @(negedge clk);
    req_valid = v[1:0];
    req_num0  = n0[W-1:0];
    req_num1  = n1[W-1:0];
    res_ready = rr[0];
    cnt_clr   = clr[0];
    rst       = r[0];
    #1;
    g = -1;
    if (r == 0 && m_busy == 0) begin
      if (v == 3) g = (m_last == 1) ? 0 : 1;
      else if (v == 1) g = 0;
      else if (v == 2) g = 1;
    end
    exp_ready = (g < 0) ? 0 : (1 << g);
    chk("req_ready", int'(req_ready), exp_ready);
    chk("res_valid", int'(res_valid), m_busy);
    chk("res_id",    int'(res_id),    m_id);
    chk("res_num",   int'(res_num),   m_num);
    chk("res_odd",   int'(res_odd),   m_odd);
    chk("even_cnt",  int'(even_cnt),  m_even);
    chk("odd_cnt",   int'(odd_cnt),   m_oddc);
    if (r != 0) begin
      m_busy = 0; m_id = 0; m_num = 0; m_odd = 0; m_last = 1;
      m_even = 0; m_oddc = 0;
    end else begin
      if (g >= 0) begin
        m_busy = 1;
        m_id   = g;
        m_num  = (g == 0) ? n0 : n1;
        m_odd  = m_num % 2;
        m_last = g;
      end else if (m_busy == 1 && rr != 0) begin
        m_busy = 0;
      end
      if (clr != 0) begin
        m_even = 0; m_oddc = 0;
      end else if (g >= 0) begin
        if (m_odd == 1) m_oddc = (m_oddc < CMAX) ? m_oddc + 1 : CMAX;
        else            m_even = (m_even < CMAX) ? m_even + 1 : CMAX;
      end
    end
  endtask

  initial begin
    // Single request
    step(0, 0, 0, 0, 0, 1);
    step(1, 6, 0, 0, 0, 0);
    chk("lit_single_ready", int'(req_ready), 1);
    step(0, 0, 0, 0, 0, 0);
    chk("lit_single_valid", int'(res_valid), 1);
    chk("lit_single_id",    int'(res_id), 0);
    chk("lit_single_num",   int'(res_num), 6);
    chk("lit_single_odd",   int'(res_odd), 0);
    chk("lit_single_even",  int'(even_cnt), 1);
    chk("lit_single_oddc",  int'(odd_cnt), 0);

    // Round-robin tie
    step(0, 0, 0, 0, 0, 1);
    step(3, 3, 14, 1, 0, 0);
    chk("lit_tie_first_ready", int'(req_ready), 1);
    step(2, 0, 14, 1, 0, 0);
    chk("lit_tie_r1_id",  int'(res_id), 0);
    chk("lit_tie_r1_num", int'(res_num), 3);
    chk("lit_tie_r1_odd", int'(res_odd), 1);
    step(2, 0, 14, 1, 0, 0);
    chk("lit_tie_second_ready", int'(req_ready), 2);
    step(1, 10, 0, 1, 0, 0);
    chk("lit_tie_r2_id",  int'(res_id), 1);
    chk("lit_tie_r2_num", int'(res_num), 14);
    chk("lit_tie_r2_odd", int'(res_odd), 0);
    step(1, 10, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("lit_tie_r3_num", int'(res_num), 10);
    chk("lit_tie_even",   int'(even_cnt), 2);
    chk("lit_tie_oddc",   int'(odd_cnt), 1);

    // Backpressure
    step(0, 0, 0, 0, 0, 1);
    step(1, 11, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(2, 0, 2, 0, 0, 0);
      chk("lit_bp_valid", int'(res_valid), 1);
      chk("lit_bp_num",   int'(res_num), 11);
      chk("lit_bp_ready", int'(req_ready), 0);
    end
    step(2, 0, 2, 1, 0, 0);
    step(2, 0, 2, 1, 0, 0);
    chk("lit_bp_idle_valid", int'(res_valid), 0);
    chk("lit_bp_idle_ready", int'(req_ready), 2);

    // Saturation and clear priority
    step(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 260; i++) begin
      step(1, 7, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
    end
    chk("lit_sat_oddc", int'(odd_cnt), 255);
    step(1, 7, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("lit_clr_oddc", int'(odd_cnt), 0);
    chk("lit_clr_even", int'(even_cnt), 0);

    // Reset during BUSY
    step(2, 0, 14, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(3, 3, 14, 0, 0, 0);
    chk("lit_rst_valid", int'(res_valid), 0);
    chk("lit_rst_even",  int'(even_cnt), 0);
    chk("lit_rst_oddc",  int'(odd_cnt), 0);
    chk("lit_rst_tie",   int'(req_ready), 1);

    // Randomized traffic; requesters hold their operand until granted.
    step(0, 0, 0, 0, 0, 1);
    pend_v[0] = 0; pend_v[1] = 0; pend_n[0] = 0; pend_n[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (pend_v[i] == 0 && $urandom_range(0, 2) != 0) begin
          pend_v[i] = 1;
          pend_n[i] = int'($urandom_range(0, (1 << W) - 1));
        end
      end
      step(pend_v[0] + 2 * pend_v[1], pend_n[0], pend_n[1],
           int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 40) == 0),
           int'($urandom_range(0, 150) == 0));
      for (int i = 0; i < 2; i++)
        if (exp_ready[i]) pend_v[i] = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
